// File: rtl/ahb_slave_arbiter.sv
// Round-robin address/data grant for one AHB slave port; grant holds across bursts and locked sequences.
// One-cycle grant latency; every update is gated by i_hready, so wait states freeze all state.
module ahb_slave_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                     i_hclk,
   input  logic                     i_hreset,
   input  logic [NUM_MASTERS-1:0]   i_req,
   input  logic [NUM_MASTERS-1:0]   i_hmastlock,
   input  logic [2*NUM_MASTERS-1:0] i_htrans,
   input  logic [3*NUM_MASTERS-1:0] i_hburst,
   input  logic                     i_hready,
   output logic [NUM_MASTERS-1:0]   o_bus_grant,
   output logic [NUM_MASTERS-1:0]   o_data_grant,
   output logic                     o_locked
);

   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_BUSY   = 2'b01;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;

   typedef enum logic [1:0] {PARK, SINGLE, BURST, LOCK} state_t;

   state_t                 state, state_nxt;
   logic [IW-1:0]          rr_ptr, rr_nxt, owner, winner;
   logic [3:0]             beats_left, beats_nxt;
   logic [NUM_MASTERS-1:0] grant_nxt, data_nxt;
   logic                   boundary, found;
   logic [1:0]             own_trans;
   logic [2:0]             own_burst;
   logic                   own_lock;

   logic [1:0] trans_m [NUM_MASTERS];
   logic [2:0] burst_m [NUM_MASTERS];

   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_split
      assign trans_m[g] = i_htrans[2*g +: 2];
      assign burst_m[g] = i_hburst[3*g +: 3];
   end

   // Remaining beats after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
   function automatic logic [3:0] burst_rem(input logic [2:0] hb);
      case (hb[2:1])
         2'b01:   burst_rem = 4'd3;
         2'b10:   burst_rem = 4'd7;
         2'b11:   burst_rem = 4'd15;
         default: burst_rem = 4'd0;
      endcase
   endfunction

   always_comb begin
      owner = '0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
         if (o_bus_grant[IW'(m)]) owner = IW'(m);
      end
   end

   assign own_trans = trans_m[owner];
   assign own_burst = burst_m[owner];
   assign own_lock  = i_hmastlock[owner];

   // Search starts just past the last winner, so the current owner is considered last.
   always_comb begin
      found  = 1'b0;
      winner = rr_ptr;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         logic [IW-1:0] cand;
         cand = IW'((int'(rr_ptr) + k) % NUM_MASTERS);
         if (!found && i_req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      beats_nxt = beats_left;
      grant_nxt = o_bus_grant;
      rr_nxt    = rr_ptr;
      data_nxt  = o_data_grant;
      boundary  = 1'b0;

      if (i_hready) begin
         data_nxt = own_trans[1] ? o_bus_grant : '0;

         if (own_lock && (own_trans[1] || state == LOCK)) begin
            state_nxt = LOCK;
            if (own_trans == HT_NONSEQ)
               beats_nxt = burst_rem(own_burst);
            else if (own_trans == HT_SEQ && beats_left != 4'd0)
               beats_nxt = beats_left - 4'd1;
         end else begin
            case (own_trans)
               HT_IDLE: boundary = 1'b1;
               HT_BUSY: begin
                  if (state == PARK) boundary = 1'b1;
                  else state_nxt = (beats_left != 4'd0) ? BURST : SINGLE;
               end
               HT_NONSEQ: begin
                  if (own_burst == 3'd0) begin
                     boundary = 1'b1;
                  end else if (own_burst == 3'd1) begin
                     state_nxt = SINGLE;
                     beats_nxt = 4'd0;
                  end else begin
                     state_nxt = BURST;
                     beats_nxt = burst_rem(own_burst);
                  end
               end
               HT_SEQ: begin
                  if (beats_left != 4'd0) begin
                     beats_nxt = beats_left - 4'd1;
                     if (beats_left == 4'd1) boundary = 1'b1;
                     else state_nxt = BURST;
                  end else if (state == PARK) begin
                     boundary = 1'b1;
                  end else begin
                     state_nxt = SINGLE;
                  end
               end
               default: boundary = 1'b1;
            endcase
         end

         if (boundary) begin
            beats_nxt = 4'd0;
            if (found) begin
               grant_nxt         = '0;
               grant_nxt[winner] = 1'b1;
               rr_nxt            = winner;
               state_nxt         = SINGLE;
            end else begin
               grant_nxt = DEF_GRANT;
               state_nxt = PARK;
            end
         end
      end
   end

   always_ff @(posedge i_hclk) begin
      if (i_hreset) begin
         state        <= PARK;
         rr_ptr       <= IW'(DEFAULT_MASTER);
         beats_left   <= 4'd0;
         o_bus_grant  <= DEF_GRANT;
         o_data_grant <= '0;
         o_locked     <= 1'b0;
      end else begin
         state        <= state_nxt;
         rr_ptr       <= rr_nxt;
         beats_left   <= beats_nxt;
         o_bus_grant  <= grant_nxt;
         o_data_grant <= data_nxt;
         o_locked     <= (state_nxt == LOCK);
      end
   end

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed bench for ahb_slave_arbiter with two masters; expectations are hand-derived per vector.
module tb_ahb_slave_arbiter;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] BUSY   = 2'b01;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;
   localparam logic [2:0] B_SGL  = 3'd0;
   localparam logic [2:0] B_INC4 = 3'd3;
   localparam logic [2:0] B_WRP8 = 3'd4;

   logic       clk;
   logic       rst;
   logic [1:0] req;
   logic [1:0] lock;
   logic [3:0] trans;
   logic [5:0] burst;
   logic       hready;
   logic [1:0] bus_grant;
   logic [1:0] data_grant;
   logic       locked;

   int checks;
   int errors;

   ahb_slave_arbiter #(.NUM_MASTERS(2), .DEFAULT_MASTER(0)) dut (
      .i_hclk       (clk),
      .i_hreset     (rst),
      .i_req        (req),
      .i_hmastlock  (lock),
      .i_htrans     (trans),
      .i_hburst     (burst),
      .i_hready     (hready),
      .o_bus_grant  (bus_grant),
      .o_data_grant (data_grant),
      .o_locked     (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic set2(input logic [1:0] t0, input logic [2:0] b0, input logic l0,
                       input logic [1:0] t1, input logic [2:0] b1, input logic l1);
      trans = {t1, t0};
      burst = {b1, b0};
      lock  = {l1, l0};
      req   = {t1[1], t0[1]};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set2(IDLE, B_SGL, 1'b0, IDLE, B_SGL, 1'b0);
      hready = 1'b1;
      rst    = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("onehot_bus", {1'b0, $onehot(bus_grant)}, 2'b01);
         check("onehot0_data", {1'b0, $onehot0(data_grant)}, 2'b01);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      hready = 1'b1;
      set2(IDLE, B_SGL, 1'b0, IDLE, B_SGL, 1'b0);
      tick();
      tick();
      check("rst_grant", bus_grant, 2'b01);
      check("rst_data", data_grant, 2'b00);
      check("rst_lock", {1'b0, locked}, 2'b00);
      rst = 1'b0;
      tick();
      check("idle_park", bus_grant, 2'b01);

      // M1 single transfer
      set2(IDLE, B_SGL, 1'b0, NONSEQ, B_SGL, 1'b0);
      tick();
      check("sgl_grant", bus_grant, 2'b10);
      check("sgl_data0", data_grant, 2'b00);
      tick();
      check("sgl_data1", data_grant, 2'b10);
      set2(IDLE, B_SGL, 1'b0, IDLE, B_SGL, 1'b0);
      tick();
      check("sgl_park", bus_grant, 2'b01);
      check("sgl_data2", data_grant, 2'b00);

      // M0 INCR4 with one BUSY while M1 waits
      do_reset();
      set2(NONSEQ, B_INC4, 1'b0, NONSEQ, B_SGL, 1'b0);
      tick();
      check("i4_b1", bus_grant, 2'b01);
      check("i4_d1", data_grant, 2'b01);
      set2(SEQ, B_INC4, 1'b0, NONSEQ, B_SGL, 1'b0);
      tick();
      check("i4_b2", bus_grant, 2'b01);
      set2(BUSY, B_INC4, 1'b0, NONSEQ, B_SGL, 1'b0);
      tick();
      check("i4_busy", bus_grant, 2'b01);
      check("i4_busy_d", data_grant, 2'b00);
      set2(SEQ, B_INC4, 1'b0, NONSEQ, B_SGL, 1'b0);
      tick();
      check("i4_b3", bus_grant, 2'b01);
      tick();
      check("i4_switch", bus_grant, 2'b10);
      check("i4_d4", data_grant, 2'b01);
      set2(IDLE, B_SGL, 1'b0, NONSEQ, B_SGL, 1'b0);
      tick();
      check("i4_m1_data", data_grant, 2'b10);

      // Same burst with two wait states after beat 2
      do_reset();
      set2(NONSEQ, B_INC4, 1'b0, NONSEQ, B_SGL, 1'b0);
      tick();
      set2(SEQ, B_INC4, 1'b0, NONSEQ, B_SGL, 1'b0);
      tick();
      hready = 1'b0;
      set2(BUSY, B_INC4, 1'b0, NONSEQ, B_SGL, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("ws_hold_g", bus_grant, 2'b01);
         check("ws_hold_d", data_grant, 2'b01);
      end
      hready = 1'b1;
      tick();
      set2(SEQ, B_INC4, 1'b0, NONSEQ, B_SGL, 1'b0);
      tick();
      check("ws_late", bus_grant, 2'b01);
      tick();
      check("ws_switch", bus_grant, 2'b10);

      // Locked sequence of three singles
      do_reset();
      set2(NONSEQ, B_SGL, 1'b1, NONSEQ, B_SGL, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("lk_grant", bus_grant, 2'b01);
         check("lk_flag", {1'b0, locked}, 2'b01);
      end
      set2(IDLE, B_SGL, 1'b0, NONSEQ, B_SGL, 1'b0);
      tick();
      check("lk_release", bus_grant, 2'b10);
      check("lk_clear", {1'b0, locked}, 2'b00);

      // Both masters streaming singles: strict alternation
      do_reset();
      set2(NONSEQ, B_SGL, 1'b0, NONSEQ, B_SGL, 1'b0);
      for (int i = 0; i < 4; i++) begin
         logic [1:0] eg;
         logic [1:0] ed;
         eg = (i % 2 == 0) ? 2'b10 : 2'b01;
         ed = (i % 2 == 0) ? 2'b01 : 2'b10;
         tick();
         check("rr_grant", bus_grant, eg);
         check("rr_data", data_grant, ed);
      end

      // Reset in the middle of an M1 WRAP8
      do_reset();
      set2(IDLE, B_SGL, 1'b0, NONSEQ, B_WRP8, 1'b0);
      tick();
      check("w8_grant", bus_grant, 2'b10);
      set2(NONSEQ, B_SGL, 1'b0, NONSEQ, B_WRP8, 1'b0);
      tick();
      check("w8_hold1", bus_grant, 2'b10);
      set2(NONSEQ, B_SGL, 1'b0, SEQ, B_WRP8, 1'b0);
      tick();
      tick();
      check("w8_hold3", bus_grant, 2'b10);
      rst = 1'b1;
      tick();
      check("w8_rst_g", bus_grant, 2'b01);
      check("w8_rst_d", data_grant, 2'b00);
      check("w8_rst_l", {1'b0, locked}, 2'b00);
      rst = 1'b0;
      set2(NONSEQ, B_SGL, 1'b0, IDLE, B_SGL, 1'b0);
      tick();
      check("w8_after_g", bus_grant, 2'b01);
      check("w8_after_d", data_grant, 2'b01);

      @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
